mem_access_ctrl: RTL

- Next-generation data-memory access unit between the CPU memory stage and a synchronous block-RAM port.
- Replaces the always-ready, zero-latency, word-only access path with a registered request/response handshake and a parametrised BRAM read latency.
- Adds byte, halfword and word accesses with sign/zero extension, per-byte write enables, and misalignment detection.

---
 rtl/mem_access_ctrl_pkg.sv | 24 ++
 rtl/mem_access_ctrl_if.sv | 26 ++
 rtl/mem_lane_align.sv | 49 ++++
 rtl/mem_access_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared constants and types for the data-memory access unit
package mem_access_ctrl_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  localparam logic [1:0] MA_IDLE  = 2'b00;
  localparam logic [1:0] MA_ISSUE = 2'b01;
  localparam logic [1:0] MA_WAIT  = 2'b10;
  localparam logic [1:0] MA_RESP  = 2'b11;

  typedef struct packed {
    logic       io;
    logic [1:0] size;
    logic       sign_ext;
  } req_attr_t;

  // Encoding 2'b11 behaves as a word access
  function automatic logic [1:0] norm_size(input logic [1:0] s);
    return (s == 2'b11) ? MEM_SIZE_W : s;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - CPU-side request/response bundle of the access unit
interface mem_access_ctrl_if #(
  parameter int LEN_WORD     = 32,
  parameter int LEN_MEM_ADDR = 32
);
  logic                    order;
  logic                    io;
  logic [1:0]              size;
  logic                    sign_ext;
  logic [LEN_MEM_ADDR-1:0] address;
  logic [LEN_WORD-1:0]     i_data;
  logic                    accepted;
  logic                    accessed;
  logic                    err;
  logic [LEN_WORD-1:0]     o_data;

  modport master (
    output order, io, size, sign_ext, address, i_data,
    input  accepted, accessed, err, o_data
  );

  modport slave (
    input  order, io, size, sign_ext, address, i_data,
    output accepted, accessed, err, o_data
  );
endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane replication, write mask and load extraction
module mem_lane_align
  import mem_access_ctrl_pkg::*;
#(
  parameter int LEN_WORD = 32,
  localparam int NB      = LEN_WORD / 8,
  localparam int OFS     = $clog2(NB)
) (
  input  logic [1:0]          size,
  input  logic                sign_ext,
  input  logic [OFS-1:0]      ofs,
  input  logic [LEN_WORD-1:0] st_data,
  input  logic [LEN_WORD-1:0] ld_word,
  output logic [LEN_WORD-1:0] st_word,
  output logic [NB-1:0]       byte_mask,
  output logic [LEN_WORD-1:0] ld_value
);

  logic [LEN_WORD-1:0] shifted;
  logic                unused_shift_hi;

  assign shifted         = ld_word >> {ofs, 3'b000};
  assign unused_shift_hi = ^shifted[LEN_WORD-1:16];

  // Replicate store data, build the lane mask and extend the selected load lane(s)
  always_comb begin
    st_word   = st_data;
    byte_mask = '1;
    ld_value  = ld_word;
    case (norm_size(size))
      MEM_SIZE_B: begin
        st_word   = {NB{st_data[7:0]}};
        byte_mask = NB'(1) << ofs;
        ld_value  = {{(LEN_WORD-8){sign_ext & shifted[7]}}, shifted[7:0]};
      end
      MEM_SIZE_H: begin
        st_word   = {(NB/2){st_data[15:0]}};
        byte_mask = NB'(3) << ofs;
        ld_value  = {{(LEN_WORD-16){sign_ext & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        st_word   = st_data;
        byte_mask = '1;
        ld_value  = ld_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - registered request/response access unit in front of a block-RAM port
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int LEN_WORD         = 32,
  parameter int LEN_MEM_ADDR     = 32,
  parameter int LEN_MEMDATA_ADDR = 17,
  parameter int READ_LATENCY     = 2,
  localparam int NB              = LEN_WORD / 8,
  localparam int OFS             = $clog2(NB),
  localparam int CW              = $clog2(READ_LATENCY + 1)
) (
  input  logic                        clk,
  input  logic                        rstn,
  mem_access_ctrl_if.slave            cpu,
  output logic [LEN_MEMDATA_ADDR-1:0] a_mem,
  output logic [LEN_WORD-1:0]         sd_mem,
  input  logic [LEN_WORD-1:0]         ld_mem,
  output logic [NB-1:0]               mem_we
);

  logic [1:0]              state;
  req_attr_t               attr_r;
  logic [LEN_MEM_ADDR-1:0] addr_r;
  logic [LEN_WORD-1:0]     data_r;
  logic                    err_r;
  logic [CW-1:0]           cnt;
  logic [LEN_WORD-1:0]     o_data_r;
  logic                    misaligned;
  logic [NB-1:0]           byte_mask;
  logic [LEN_WORD-1:0]     ld_value;

  mem_lane_align #(.LEN_WORD(LEN_WORD)) u_align (
    .size      (attr_r.size),
    .sign_ext  (attr_r.sign_ext),
    .ofs       (addr_r[OFS-1:0]),
    .st_data   (data_r),
    .ld_word   (ld_mem),
    .st_word   (sd_mem),
    .byte_mask (byte_mask),
    .ld_value  (ld_value)
  );

  // Alignment check on the incoming request, decided before it is latched
  always_comb begin
    misaligned = 1'b0;
    case (norm_size(cpu.size))
      MEM_SIZE_B: misaligned = 1'b0;
      MEM_SIZE_H: misaligned = cpu.address[0];
      default:    misaligned = |cpu.address[OFS-1:0];
    endcase
  end

  // Request latch, FSM sequencing, latency counter and load result capture
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= MA_IDLE;
      attr_r   <= '0;
      addr_r   <= '0;
      data_r   <= '0;
      err_r    <= 1'b0;
      cnt      <= '0;
      o_data_r <= '0;
    end else begin
      case (state)
        MA_IDLE: begin
          if (cpu.order) begin
            attr_r.io       <= cpu.io;
            attr_r.size     <= cpu.size;
            attr_r.sign_ext <= cpu.sign_ext;
            addr_r          <= cpu.address;
            data_r          <= cpu.i_data;
            err_r           <= misaligned;
            state           <= misaligned ? MA_RESP : MA_ISSUE;
          end
        end
        MA_ISSUE: begin
          if (attr_r.io) begin
            state <= MA_RESP;
          end else begin
            cnt   <= CW'(READ_LATENCY - 1);
            state <= MA_WAIT;
          end
        end
        MA_WAIT: begin
          if (cnt == '0) begin
            o_data_r <= ld_value;
            state    <= MA_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= MA_IDLE;
      endcase
    end
  end

  assign cpu.accepted = (state == MA_IDLE);
  assign cpu.accessed = (state == MA_RESP);
  assign cpu.err      = err_r;
  assign cpu.o_data   = o_data_r;

  assign a_mem  = addr_r[LEN_MEMDATA_ADDR+OFS-1:OFS];
  assign mem_we = (state == MA_ISSUE && attr_r.io) ? byte_mask : '0;

  // Address bits above the BRAM range are intentionally ignored
  generate
    if (LEN_MEM_ADDR > LEN_MEMDATA_ADDR + OFS) begin : g_unused_addr
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr_r[LEN_MEM_ADDR-1:LEN_MEMDATA_ADDR+OFS];
    end
  endgenerate

endmodule
